// File: rtl/kingdom_phi_fib_engine.sv
// kingdom_phi_fib_engine
// Sequential Fibonacci/Lucas engine. It accepts an index n and walks the
// Fibonacci recurrence one step per clock. When the walk is done it reports
// F(n) and L(n) = F(n) + 2*F(n-1) as exact unsigned integers.
// At acceptance it also checks the phi/trinity doubles from the constants
// layer against their canonical encodings. The result is informational only.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   phi       : IEEE-754 double for phi, sampled on acceptance only
//   trinity   : IEEE-754 double for 3.0, sampled on acceptance only
//   in_valid  : request valid
//   in_ready  : engine idle and able to accept a request
//   in_n      : requested index n (unsigned)
//   out_valid : result valid (state DONE)
//   out_ready : consumer accepts the result
//   fib       : F(n)
//   lucas     : L(n)
//   err       : n was above N_MAX, so fib and lucas are forced to zero
//   const_ok  : phi and trinity matched their canonical words at acceptance
//   busy      : engine is not idle
module kingdom_phi_fib_engine #(
  parameter int WIDTH = 64,
  parameter int N_MAX = 92
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      phi,
  input  logic [63:0]      trinity,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] fib,
  output logic [WIDTH-1:0] lucas,
  output logic             err,
  output logic             const_ok,
  output logic             busy
);

  localparam logic [63:0] PHI_CANON     = 64'h3FF9E3779B97F4A8;
  localparam logic [63:0] TRINITY_CANON = 64'h4008000000000000;
  localparam logic [6:0]  N_MAX_N       = 7'(N_MAX);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;       // F(k)
  logic [WIDTH-1:0] c_q, c_d;       // F(k-1); F(-1) = 1 seeds the walk
  logic [WIDTH-1:0] fib_q, fib_d;
  logic [WIDTH-1:0] lucas_q, lucas_d;
  logic             err_q, err_d;
  logic             const_ok_q, const_ok_d;

  // L(k) = F(k) + 2*F(k-1). The full sum is 65 bits, and only the low WIDTH
  // bits are kept. Taking a + (c << 1) modulo 2^WIDTH gives the same low
  // bits, and the value fits for every n <= N_MAX.
  function automatic logic [WIDTH-1:0] calc_lucas(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] c);
    return a + {c[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    c_d        = c_q;
    fib_d      = fib_q;
    lucas_d    = lucas_q;
    err_d      = err_q;
    const_ok_d = const_ok_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          const_ok_d = (phi == PHI_CANON) && (trinity == TRINITY_CANON);
          if (in_n > N_MAX_N) begin
            // Out of range: report the error immediately, without iterating.
            state_d = DONE;
            err_d   = 1'b1;
            fib_d   = '0;
            lucas_d = '0;
          end else begin
            state_d = RUN;
            cnt_d   = in_n;
            a_d     = '0;
            c_d     = WIDTH'(1);
          end
        end
      end
      RUN: begin
        if (cnt_q != 7'd0) begin
          c_d   = a_q;
          a_d   = a_q + c_q;
          cnt_d = cnt_q - 7'd1;
        end else begin
          fib_d   = a_q;
          lucas_d = calc_lucas(a_q, c_q);
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      c_q        <= '0;
      fib_q      <= '0;
      lucas_q    <= '0;
      err_q      <= 1'b0;
      const_ok_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      c_q        <= c_d;
      fib_q      <= fib_d;
      lucas_q    <= lucas_d;
      err_q      <= err_d;
      const_ok_q <= const_ok_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign fib       = fib_q;
  assign lucas     = lucas_q;
  assign err       = err_q;
  assign const_ok  = const_ok_q;

endmodule

// File: doc/kingdom_phi_fib_engine.md
# kingdom_phi_fib_engine

Sequential Fibonacci/Lucas engine that sits directly downstream of `kingdom_sacred_constants`. It consumes the `phi` and `trinity` IEEE-754 double words, checks them against their canonical encodings, and computes F(n) and L(n) = phi^n + (-phi)^-n as exact unsigned integers. Requests and results use valid/ready handshakes. It is the integer reference the sacred layer uses to cross-check the identity phi^2 + phi^-2 = 3 = trinity, i.e. L(2) = 3.

## Interface
- `WIDTH`, 64: result width; only 64 is supported and verified.
- `N_MAX`, 92: largest n whose F(n) and L(n) fit in `WIDTH` bits.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `phi` in 64: double from the constants layer.
- `trinity` in 64: double from the constants layer.
- `in_valid` in 1: request valid.
- `in_ready` out 1: engine can accept a request.
- `in_n` in 7: index n, unsigned.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `fib` out 64: F(n).
- `lucas` out 64: L(n).
- `err` out 1: n > N_MAX.
- `const_ok` out 1: at acceptance, `phi`==64'h3FF9E3779B97F4A8 and `trinity`==64'h4008000000000000.
- `busy` out 1: state != IDLE.

## Operation
- States: IDLE, RUN, DONE.
- Internal registers:
  - cnt (7b)
  - a = F(k)
  - c = F(k-1)
  - each 64b.
- `in_ready` = (state==IDLE). Acceptance = `in_valid` & `in_ready` at a rising edge.
- On acceptance with n ≤ N_MAX:
  - cnt←n, a←0, c←1, state←RUN.
  - `const_ok` is registered from the current `phi`/`trinity` values.
- On acceptance with n > N_MAX:
  - state←DONE, err←1, fib←0, lucas←0.
  - `const_ok` is registered from the current inputs.
- RUN, cnt≠0: c←a, a←a+c (64b, never overflows for n≤92), cnt←cnt−1.
- RUN, cnt==0: fib←a, lucas←a+2c, err←0, state←DONE.
  - The sum is computed 65b wide and truncated; it fits for n≤92.
- DONE: `out_valid`=1. On `out_ready`, state←IDLE.
  - `fib`/`lucas`/`err`/`const_ok` hold their values until the next result is registered.
- `in_valid` is ignored while not IDLE. A request stays pending at the source; it is not buffered.
- `const_ok` is informational only; computation proceeds regardless.

## Timing
- Reset (async, any state): state=IDLE, `out_valid`=0, `in_ready`=1, `busy`=0, `fib`=0, `lucas`=0, `err`=0, `const_ok`=0.
  - An in-flight request is discarded; no result is emitted.
- Latency: `out_valid` rises n+1 edges after the acceptance edge for n≤92, and 1 edge after for n>92.
- The handshake completes on the edge where `out_valid`&`out_ready`. `in_ready` rises on that same edge.
  - Earliest next acceptance is the following edge, so there are no back-to-back overlaps.
- `out_ready` held high while entering DONE: result valid for exactly one cycle.
- `out_ready` low: all outputs stable; `in_ready` stays 0.
- `phi`/`trinity` are sampled only on the acceptance edge. Later changes do not affect `const_ok`.
- Outputs are registered; there are no combinational paths from inputs to outputs except through `in_ready`/state.

## Test plan
- Reset release, constants from `kingdom_sacred_constants`, n=0:
  - `in_ready`=1 before the request.
  - `out_valid` 1 edge after acceptance.
  - fib=0, lucas=2, err=0, const_ok=1.
- n=2 → fib=1, lucas=3 (trinity identity), latency 3 edges. Then n=10 → fib=55, lucas=123, latency 11 edges.
- n=92 → fib=7540113804746346429, lucas=16860207025497407047, err=0, latency 93 edges. Then n=93 → err=1, fib=0, lucas=0, latency 1 edge.
- Backpressure, n=5: hold `out_ready`=0 for 5 cycles after `out_valid`.
  - fib=5, lucas=11 stable throughout.
  - `in_ready`=0 and `in_valid` pulses ignored.
  - After `out_ready`, `in_ready`=1 on the same edge.
- Corrupt the constants with phi=64'h3FF9E3779B97F4A9 at acceptance and restore it during RUN, n=3:
  - fib=2, lucas=4, const_ok=0.
- Assert `rst_n` low mid-RUN with n=50:
  - Outputs go to reset values immediately (asynchronously).
  - No `out_valid` ever appears for that request.
  - A new request n=1 then yields fib=1, lucas=1.
